imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 26 ++
 rtl/imem_loader_if.sv | 24 ++
 rtl/imem_byte_packer.sv | 40 ++++
 rtl/imem_loader.sv | 157 +++++++++++++++
 tb/tb_imem_loader.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg -- shared types and constants for the instruction-memory loader.
//   ld_state_e      : loader FSM state encoding
//   HDR_BYTES       : length-header size in bytes (little-endian word count)
//   BYTES_PER_WORD  : bytes per 32-bit instruction word
//   word_addr()     : word index -> word-aligned byte address
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds the CKSUM state.
package imem_loader_pkg;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_LEN0, ST_LEN1, ST_DATA, ST_CKSUM, ST_DONE, ST_ERR
    } ld_state_e;
`else
    typedef enum logic [2:0] {
        ST_LEN0, ST_LEN1, ST_DATA, ST_DONE, ST_ERR
    } ld_state_e;
`endif

    function automatic logic [31:0] word_addr(input logic [15:0] idx);
        return {14'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if -- byte-stream input and instruction-memory write bus.
//   byte_valid/byte_data/byte_ready : program byte stream (valid/ready)
//   imem_we/imem_addr/imem_wdata    : instruction-memory write port
// Modports:
//   slave  : the loader (consumes bytes, drives the memory write port)
//   master : the environment (sources bytes, observes the write port)
interface imem_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, imem_we, imem_addr, imem_wdata
    );

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_byte_packer.sv
// imem_byte_packer -- assembles little-endian 32-bit words from a byte stream.
//   clk, arst : clock, synchronous active-high reset
//   clr       : drop any partial word and restart at byte 0
//   push      : a byte is accepted this cycle
//   din       : the byte
//   word      : assembled word including the current byte (valid with last)
//   last      : this push completes a word (4th byte)
module imem_byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        arst,
    input  logic        clr,
    input  logic        push,
    input  logic [7:0]  din,
    output logic [31:0] word,
    output logic        last
);

    localparam int CNT_W = $clog2(BYTES_PER_WORD);

    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      word_q;

    // Bytes enter at the top and shift down, so the first byte of a word
    // ends up in bits 7:0 once all four have arrived.
    assign word = {din, word_q[31:8]};
    assign last = push && (cnt_q == CNT_W'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk) begin
        if (arst || clr) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else if (push) begin
            cnt_q  <= cnt_q + CNT_W'(1);  // wraps back to 0 after the 4th byte
            word_q <= word;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader -- boot loader: receives a length-prefixed program over a byte
// stream, writes it into instruction memory and then releases the CPU.
//   Parameter MAX_WORDS : memory depth in words / largest accepted program
//   clk     : clock
//   arst    : synchronous active-high reset
//   reload  : restart loading (only from DONE or ERR)
//   bus     : imem_loader_if.slave (byte stream in, imem write port out)
//   cpu_rst : CPU held in reset while high (everywhere except DONE)
//   done    : program loaded
//   error   : load failed (oversize program or checksum mismatch)
// Stream: N[7:0], N[15:8], then N little-endian words.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN -- one trailing byte equal to
// the XOR of every preceding stream byte is required before DONE.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int MAX_WORDS = 256
)(
    input  logic         clk,
    input  logic         arst,
    input  logic         reload,
    imem_loader_if.slave bus,
    output logic         cpu_rst,
    output logic         done,
    output logic         error
);

    localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam ld_state_e ST_POST = ST_CKSUM;
`else
    localparam ld_state_e ST_POST = ST_DONE;
`endif

    ld_state_e   state_q, state_d;
    logic [7:0]  len_lo_q;
    logic [15:0] n_words_q;
    logic [15:0] idx_q;
    logic        rdy_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic        accepting;
    logic        acc;
    logic        reload_go;
    logic        pack_push;
    logic        word_last;
    logic        last_word;
    logic [15:0] n_in;
    logic [31:0] packed_word;

    // rdy_q keeps byte_ready low during reset and for the first edge after
    // it, so the source sees ready rise one cycle after reset is released.
    assign bus.byte_ready = rdy_q && accepting;
    assign acc            = bus.byte_valid && bus.byte_ready;
    assign n_in           = {bus.byte_data, len_lo_q};
    assign pack_push      = acc && (state_q == ST_DATA);
    assign last_word      = (idx_q + 16'd1) == n_words_q;
    assign reload_go      = reload && ((state_q == ST_DONE) || (state_q == ST_ERR));

    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;

    assign cpu_rst = (state_q != ST_DONE);
    assign done    = (state_q == ST_DONE);
    assign error   = (state_q == ST_ERR);

    imem_byte_packer u_packer (
        .clk  (clk),
        .arst (arst),
        .clr  (reload_go),
        .push (pack_push),
        .din  (bus.byte_data),
        .word (packed_word),
        .last (word_last)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] cksum_q;

    always_ff @(posedge clk) begin
        if (arst || reload_go) begin
            cksum_q <= '0;
        end else if (acc && (state_q != ST_CKSUM)) begin
            cksum_q <= cksum_q ^ bus.byte_data;
        end
    end
`endif

    always_comb begin
        accepting = 1'b0;
        case (state_q)
            ST_LEN0, ST_LEN1, ST_DATA: accepting = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CKSUM:                  accepting = 1'b1;
`endif
            default:                   accepting = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LEN0: if (acc) state_d = ST_LEN1;
            ST_LEN1: begin
                if (acc) begin
                    if ({1'b0, n_in} > MAX_N) state_d = ST_ERR;
                    else if (n_in == 16'd0)   state_d = ST_POST;
                    else                      state_d = ST_DATA;
                end
            end
            // Leave DATA on the edge that completes the last word; its write
            // pulse appears in the first cycle of the next state.
            ST_DATA: if (word_last && last_word) state_d = ST_POST;
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CKSUM: begin
                if (acc) state_d = (bus.byte_data == cksum_q) ? ST_DONE : ST_ERR;
            end
`endif
            ST_DONE, ST_ERR: if (reload) state_d = ST_LEN0;
            default: state_d = ST_LEN0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (arst) state_q <= ST_LEN0;
        else      state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            rdy_q     <= 1'b0;
            len_lo_q  <= '0;
            n_words_q <= '0;
            idx_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            rdy_q <= 1'b1;
            we_q  <= 1'b0;
            if (reload_go) idx_q <= '0;
            if (acc && (state_q == ST_LEN0)) len_lo_q  <= bus.byte_data;
            if (acc && (state_q == ST_LEN1)) n_words_q <= n_in;
            if (word_last) begin
                we_q    <= 1'b1;
                addr_q  <= word_addr(idx_q);
                wdata_q <= packed_word;
                idx_q   <= idx_q + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader -- scoreboard bench for imem_loader. Stimulus pushes expected
// memory writes and expected status snapshots into queues; a monitor process
// compares them against the DUT on the falling clock edge.
// Honours IMEM_LOADER_CHECKSUM_EN (trailing checksum bytes, checksum tests).
module tb_imem_loader;
    import imem_loader_pkg::*;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        string name;
        logic  done;
        logic  error;
        logic  cpu_rst;
        logic  byte_ready;
        bit    chk_bus;
    } st_t;

    logic clk = 1'b0;
    logic arst, reload;
    logic cpu_rst, done, error;

    imem_loader_if bus();

    imem_loader #(.MAX_WORDS(256)) dut (
        .clk     (clk),
        .arst    (arst),
        .reload  (reload),
        .bus     (bus),
        .cpu_rst (cpu_rst),
        .done    (done),
        .error   (error)
    );

    always #5 clk = ~clk;

    wr_t exp_w[$];
    st_t exp_s[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    bit  end_chk = 0;
    bit  mon_done = 0;
    int  gap_tab[8] = '{3, 0, 5, 1, 2, 0, 4, 1};

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        bit  prev_we;
        wr_t e;
        st_t s;
        prev_we = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.imem_we === 1'b1) begin
                if (prev_we) begin
                    n_cmp++; n_bad++;
                    $display("FAIL we_pulse_width: imem_we high 2 cycles in a row, required 1-cycle pulse");
                end
                n_cmp++;
                if (exp_w.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_write: addr=%h data=%h, required no write",
                             bus.imem_addr, bus.imem_wdata);
                end else begin
                    e = exp_w.pop_front();
                    if (bus.imem_addr !== e.addr || bus.imem_wdata !== e.data) begin
                        n_bad++;
                        $display("FAIL write: addr=%h data=%h, required addr=%h data=%h",
                                 bus.imem_addr, bus.imem_wdata, e.addr, e.data);
                    end
                end
            end
            prev_we = (bus.imem_we === 1'b1);
            while (exp_s.size() > 0) begin
                s = exp_s.pop_front();
                n_cmp++;
                if ({done, error, cpu_rst, bus.byte_ready} !==
                    {s.done, s.error, s.cpu_rst, s.byte_ready}) begin
                    n_bad++;
                    $display("FAIL %s: done/error/cpu_rst/byte_ready=%b%b%b%b, required %b%b%b%b",
                             s.name, done, error, cpu_rst, bus.byte_ready,
                             s.done, s.error, s.cpu_rst, s.byte_ready);
                end
                if (s.chk_bus) begin
                    n_cmp++;
                    if ({bus.imem_we, bus.imem_addr, bus.imem_wdata} !== 65'd0) begin
                        n_bad++;
                        $display("FAIL %s_bus: we=%b addr=%h wdata=%h, required all zero",
                                 s.name, bus.imem_we, bus.imem_addr, bus.imem_wdata);
                    end
                end
            end
            if (end_chk && !mon_done) begin
                while (exp_w.size() > 0) begin
                    e = exp_w.pop_front();
                    n_cmp++; n_bad++;
                    $display("FAIL missing_write: no imem_we pulse observed, required addr=%h data=%h", e.addr, e.data);
                end
                mon_done = 1'b1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic expect_st(input string name, input logic d, input logic e,
                             input logic c, input logic r, input bit chk_bus);
        st_t s;
        s.name = name; s.done = d; s.error = e; s.cpu_rst = c; s.byte_ready = r;
        s.chk_bus = chk_bus;
        exp_s.push_back(s);
    endtask

    task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a; w.data = d;
        exp_w.push_back(w);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        int t;
        ok = 1'b0; t = 0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        while (!ok) begin
            @(negedge clk);
            ok = (bus.byte_ready === 1'b1);
            @(posedge clk); #1;
            t++;
            if (!ok && t > 30) begin
                $display("FAIL byte_accept: byte %h not taken in 30 cycles, required byte_ready=1", b);
                $fatal(1, "stream stalled");
            end
        end
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h5A;
    endtask

    // Bytes are listed first-to-last from the most significant end of bs.
    task automatic send_stream(input logic [95:0] bs, input int len, input bit gappy);
        for (int i = 0; i < len; i++) begin
            send_byte(bs[8*(len-1-i) +: 8]);
            if (gappy && i != len - 1) repeat (gap_tab[i % 8]) tick();
        end
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        tick();
        reload = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin : stim
        arst = 1'b1; reload = 1'b0;
        bus.byte_valid = 1'b0; bus.byte_data = 8'h5A;
        repeat (3) tick();
        expect_st("reset", 0, 0, 1, 0, 1);
        tick();
        arst = 1'b0;
        expect_st("ready_low_after_arst", 0, 0, 1, 0, 0);
        tick();
        expect_st("ready_rises", 0, 0, 1, 1, 0);
        tick();

        // two-word program, back-to-back bytes
        expect_wr(32'h0, 32'h00A00513);
        expect_wr(32'h4, 32'h00B00593);
        send_stream(96'h0200_1305_A000_9305_B000, 2 + 2 * BYTES_PER_WORD, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h92);
`endif
        expect_st("t1_done", 1, 0, 0, 0, 0);
        tick();
        pulse_reload();
        expect_st("t1_reload", 0, 0, 1, 1, 0);
        tick();

        // empty program
        send_stream(96'h0000, HDR_BYTES, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h00);
`endif
        tick();
        expect_st("t2_empty_done", 1, 0, 0, 0, 0);
        tick();
        pulse_reload();
        expect_st("t2_reload", 0, 0, 1, 1, 0);
        tick();

        // N = 257 is rejected
        send_stream(96'h0101, HDR_BYTES, 0);
        tick();
        expect_st("t3_too_long", 0, 1, 1, 0, 0);
        tick();
        pulse_reload();
        expect_st("t3_reload", 0, 0, 1, 1, 0);
        tick();

        // N = 256 is the largest accepted program: loader enters DATA
        send_stream(96'h0001, HDR_BYTES, 0);
        expect_st("t3_max_accepted", 0, 0, 1, 1, 0);
        tick();

        // reset mid-load (also abandons the N=256 load above), then reload
        arst = 1'b1;
        tick();
        arst = 1'b0;
        tick();
        send_stream(96'h0100_AABB_CC, 5, 0);
        arst = 1'b1;
        tick(); tick();
        expect_st("t4_in_reset", 0, 0, 1, 0, 1);
        tick();
        arst = 1'b0;
        tick();
        expect_wr(32'h0, 32'h44332211);
        send_stream(96'h0100_1122_3344, 6, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h45);
`endif
        expect_st("t4_done", 1, 0, 0, 0, 0);
        tick();
        pulse_reload();

        // gapped stream; reload mid-load must be ignored
        expect_wr(32'h0, 32'h00A00513);
        expect_wr(32'h4, 32'h00B00593);
        send_stream(96'h0200, HDR_BYTES, 1);
        pulse_reload();
        expect_st("t5_reload_ignored", 0, 0, 1, 1, 0);
        tick();
        send_stream(96'h1305_A000_9305_B000, 8, 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        tick();
        send_byte(8'h92);
`endif
        expect_st("t5_gapped_done", 1, 0, 0, 0, 0);
        tick();
        pulse_reload();

`ifdef IMEM_LOADER_CHECKSUM_EN
        expect_wr(32'h0, 32'hDEADBEEF);
        send_stream(96'h0100_EFBE_ADDE_23, 7, 0);
        expect_st("t6_cksum_ok", 1, 0, 0, 0, 0);
        tick();
        pulse_reload();
        expect_wr(32'h0, 32'hDEADBEEF);
        send_stream(96'h0100_EFBE_ADDE_24, 7, 0);
        expect_st("t6_cksum_bad", 0, 1, 1, 0, 0);
        tick();
        pulse_reload();
        expect_wr(32'h0, 32'hDEADBEEF);
        send_stream(96'h0100_EFBE_ADDE_23, 7, 0);
        expect_st("t6_resend_ok", 1, 0, 0, 0, 0);
        tick();
`endif

        repeat (3) tick();
        end_chk = 1'b1;
        for (int i = 0; i < 10 && !mon_done; i++) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
